serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller that sequences a single `full_addr` instance over WIDTH cycles. It is the area-minimal alternative to the 8-bit ripple-carry adder.
- Accepts operands on a start handshake and shifts them LSB-first through the full adder, holding the carry between cycles.
- Returns the WIDTH-bit sum plus carry-out with a one-cycle done pulse.

---
 rtl/serial_adder_ctrl_pkg.sv | 17 +
 rtl/serial_adder_ctrl_full_addr.sv | 22 ++
 rtl/serial_adder_ctrl.sv | 160 ++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_pkg
// Shared constants for the bit-serial adder controller and its bench:
//   - state_t      : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - DEFAULT_WIDTH: default operand/sum width
// ---------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_addr.sv
// ---------------------------------------------------------------------------
// full_addr
// One-bit combinational full adder, the single arithmetic element that the
// serial adder controller time-multiplexes across all operand bits.
// Ports:
//   in1, in2 : operand bits
//   cin      : carry in
//   sum      : in1 ^ in2 ^ cin
//   carry    : majority(in1, in2, cin)
// ---------------------------------------------------------------------------
module full_addr (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = in1 ^ in2 ^ cin;
    assign carry = (in1 & in2) | (in1 & cin) | (in2 & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in on an
// accepted start, then feeds them LSB-first through one full_addr, one bit
// per clock, and reports the WIDTH-bit sum and carry-out with a one-cycle
// done pulse. start is accepted only in IDLE or DONE (back-to-back).
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (priority over start)
//   start  : request a new addition
//   in1    : operand A (WIDTH bits), captured on accepted start
//   in2    : operand B (WIDTH bits), captured on accepted start
//   cin    : carry-in, captured on accepted start
//   busy   : high while in RUN
//   done   : one-cycle result-valid pulse (state DONE)
//   sum    : WIDTH-bit result, held until the next accepted start
//   carry  : carry-out of the MSB, same validity as sum
//   ovf    : signed overflow (only with SERIAL_ADDER_OVF_EN defined)
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
// ---------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_shift;
    logic             cy_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             accept;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_carry;

    full_addr u_full_addr (
        .in1   (a_reg[0]),
        .in2   (b_reg[0]),
        .cin   (cy_reg),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Sum register shifts right; the freshly computed bit enters at the MSB,
    // so after WIDTH shifts bit 0 of the result has reached sum_reg[0].
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
            assign sum_shift[gi] = sum_reg[gi+1];
        end
    endgenerate
    assign sum_shift[WIDTH-1] = fa_sum;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_bit   = (cnt_reg == LAST_BIT);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            cy_reg  <= 1'b0;
            cnt_reg <= '0;
        end else if (accept) begin
            // sum_reg is left alone so a finished result stays visible
            // during the DONE cycle of a back-to-back start.
            a_reg   <= in1;
            b_reg   <= in2;
            cy_reg  <= cin;
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            sum_reg <= sum_shift;
            cy_reg  <= fa_carry;
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;

    // On the MSB edge cy_reg is the carry into the MSB stage and fa_carry
    // is the carry out of it; their XOR is the signed overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_bit) begin
            ovf_reg <= cy_reg ^ fa_carry;
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign sum   = sum_reg;
    assign carry = cy_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Directed-vector bench for serial_adder_ctrl at the default width.
// Inputs change 1 time unit after a rising edge; outputs are observed at the
// same point, i.e. reflecting the state registered at that edge.
// Optional-feature checks are compiled when SERIAL_ADDER_OVF_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one addition and waits (bounded) for done. lat is the number of
    // edges after the accepting edge until done is seen, or -1 on timeout.
    // busy_bad counts cycles before done where busy was not 1.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, output int lat, output int busy_bad);
        in1 = a; in2 = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        busy_bad = 0;
        for (int n = 1; n <= 20; n++) begin
            if (busy !== 1'b1) busy_bad++;
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in1 = 8'hFF; in2 = 8'hFF; cin = 1'b1;
        tick(); tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", carry); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
        $display("reset: busy=%b done=%b sum=%h carry=%b", busy, done, sum, carry);
    endtask

    task automatic test_basic();
        int lat, bb;
        run_add(8'h35, 8'h4A, 1'b0, lat, bb);
        $display("add 35+4A+0: lat=%0d sum=%h carry=%b", lat, sum, carry);
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy_gaps got=%0d exp=0", bb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        checks++; if (sum !== 8'h7F) begin errors++; $display("FAIL basic_sum got=%h exp=7F", sum); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL basic_carry got=%b exp=0", carry); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        tick(); tick();
        checks++; if (sum !== 8'h7F) begin errors++; $display("FAIL basic_sum_hold got=%h exp=7F", sum); end
    endtask

    task automatic test_carry_wrap();
        int lat, bb;
        run_add(8'hFF, 8'h01, 1'b0, lat, bb);
        $display("add FF+01+0: lat=%0d sum=%h carry=%b", lat, sum, carry);
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL wrap1_sum got=%h exp=00", sum); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL wrap1_carry got=%b exp=1", carry); end
        tick(); tick();
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL wrap1_carry_hold got=%b exp=1", carry); end
        run_add(8'hFF, 8'hFF, 1'b1, lat, bb);
        $display("add FF+FF+1: lat=%0d sum=%h carry=%b", lat, sum, carry);
        checks++; if (sum !== 8'hFF) begin errors++; $display("FAIL wrap2_sum got=%h exp=FF", sum); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL wrap2_carry got=%b exp=1", carry); end
        tick();
    endtask

    task automatic test_ignore_busy();
        int lat, extra;
        in1 = 8'h10; in2 = 8'h20; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        // RUN cycle 3: try to inject a second operation
        in1 = 8'hAA; in2 = 8'h55; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int n = 4; n <= 20; n++) begin
            tick();
            if (done === 1'b1) begin lat = n; break; end
        end
        $display("add 10+20 (start AA+55 ignored): lat=%0d sum=%h carry=%b", lat, sum, carry);
        checks++; if (lat !== 8) begin errors++; $display("FAIL ignore_latency got=%0d exp=8", lat); end
        checks++; if (sum !== 8'h30) begin errors++; $display("FAIL ignore_sum got=%h exp=30", sum); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL ignore_carry got=%b exp=0", carry); end
        extra = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_second_op got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat, bb;
        in1 = 8'h12; in2 = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        // second operand pair, only sampled at the DONE edge
        in1 = 8'h01; in2 = 8'h02; cin = 1'b1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done === 1'b1) begin lat = n; break; end
        end
        $display("b2b first 12+34+0: lat=%0d sum=%h carry=%b", lat, sum, carry);
        checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=8", lat); end
        checks++; if (sum !== 8'h46) begin errors++; $display("FAIL b2b_first_sum got=%h exp=46", sum); end
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_next got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_low got=%b exp=0", done); end
        lat = -1;
        bb = 0;
        for (int n = 1; n <= 20; n++) begin
            if (busy !== 1'b1) bb++;
            tick();
            if (done === 1'b1) begin lat = n; break; end
        end
        $display("b2b second 01+02+1: lat=%0d sum=%h carry=%b", lat, sum, carry);
        checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=8", lat); end
        checks++; if (sum !== 8'h04) begin errors++; $display("FAIL b2b_second_sum got=%h exp=04", sum); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL b2b_second_carry got=%b exp=0", carry); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat, bb, seen;
        in1 = 8'h80; in2 = 8'h80; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("reset mid-run: busy=%b done=%b sum=%h carry=%b", busy, done, sum, carry);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL abort_sum got=%h exp=00", sum); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL abort_carry got=%b exp=0", carry); end
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
        run_add(8'h80, 8'h80, 1'b0, lat, bb);
        $display("add 80+80+0: lat=%0d sum=%h carry=%b", lat, sum, carry);
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rerun_sum got=%h exp=00", sum); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL rerun_carry got=%b exp=1", carry); end
        tick();
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        int lat, bb;
        run_add(8'h7F, 8'h01, 1'b0, lat, bb);
        $display("ovf 7F+01+0: sum=%h carry=%b ovf=%b", sum, carry, ovf);
        checks++; if (sum !== 8'h80) begin errors++; $display("FAIL ovf1_sum got=%h exp=80", sum); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL ovf1_carry got=%b exp=0", carry); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf1_ovf got=%b exp=1", ovf); end
        tick(); tick();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf1_hold got=%b exp=1", ovf); end
        run_add(8'hFF, 8'h01, 1'b0, lat, bb);
        $display("ovf FF+01+0: sum=%h carry=%b ovf=%b", sum, carry, ovf);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf2_ovf got=%b exp=0", ovf); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL ovf2_carry got=%b exp=1", carry); end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; cin = 1'b0;
        test_reset();
        test_basic();
        test_carry_wrap();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
